// File: rtl/kyber_pkg.sv
// ----------------------------------------------------------------------------
// kyber_pkg
// Shared ML-KEM-768 constants for the ciphertext path: module rank, compression
// widths, ciphertext length, bank slot assignments of the compressed
// polynomials, and the state encoding of the ciphertext packer.
// ----------------------------------------------------------------------------
package kyber_pkg;

    localparam int KYBER_K    = 3;     // number of u polynomials
    localparam int KYBER_N    = 256;   // coefficients per polynomial
    localparam int KYBER_DU   = 10;    // bits per compressed u coefficient
    localparam int KYBER_DV   = 4;     // bits per compressed v coefficient
    localparam int CT_BYTES   = 1088;  // ciphertext length in bytes

    localparam int SLOT_CT_U0 = 16;    // bank slot of u[0]; u[i] at +i
    localparam int SLOT_CT_V  = 19;    // bank slot of compressed v

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_LATCH,
        ST_EMIT,
        ST_DONE
    } ct_state_e;

endpackage

// File: rtl/ct_bit_accum.sv
// ----------------------------------------------------------------------------
// ct_bit_accum
// Little-endian bit accumulator for the ciphertext packer. A load merges the
// low load_width bits of load_data above the bits already held; a pop drops
// the lowest byte.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   clr             empty the accumulator (start of a run)
//   load            merge load_data[load_width-1:0] at bit position cnt
//   load_width      number of valid bits in load_data
//   load_data       raw coefficient; bits at and above load_width are ignored
//   pop             discard the low byte (cnt -= 8)
//   acc_byte        current low byte of the accumulator
//   has_byte        at least 8 bits held
//   load_has_byte   a load this cycle would leave at least 8 bits
//   pop_has_byte    a pop this cycle would leave at least 8 bits
// ----------------------------------------------------------------------------
module ct_bit_accum #(
    parameter int ACC_W  = 24,
    parameter int CNT_W  = 5,
    parameter int DATA_W = 12,
    parameter int WID_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              load,
    input  logic [WID_W-1:0]  load_width,
    input  logic [DATA_W-1:0] load_data,
    input  logic              pop,
    output logic [7:0]        acc_byte,
    output logic              has_byte,
    output logic              load_has_byte,
    output logic              pop_has_byte
);

    logic [ACC_W-1:0]  acc_reg, acc_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic [DATA_W-1:0] mask;

    // Per-bit keep mask: bit gi survives only when it lies below load_width.
    generate
        for (genvar gi = 0; gi < DATA_W; gi++) begin : g_mask
            assign mask[gi] = (WID_W'(gi) < load_width);
        end
    endgenerate

    always_comb begin
        acc_next = acc_reg;
        cnt_next = cnt_reg;
        if (clr) begin
            acc_next = '0;
            cnt_next = '0;
        end else if (load) begin
            // Bits above cnt are always zero, so OR-ing in the shifted field
            // is a clean append.
            acc_next = acc_reg | (ACC_W'(load_data & mask) << cnt_reg);
            cnt_next = cnt_reg + CNT_W'(load_width);
        end else if (pop) begin
            acc_next = acc_reg >> 8;
            cnt_next = cnt_reg - CNT_W'(8);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_reg <= '0;
            cnt_reg <= '0;
        end else begin
            acc_reg <= acc_next;
            cnt_reg <= cnt_next;
        end
    end

    assign acc_byte      = acc_reg[7:0];
    assign has_byte      = (cnt_reg >= CNT_W'(8));
    assign load_has_byte = ((cnt_reg + CNT_W'(load_width)) >= CNT_W'(8));
    assign pop_has_byte  = (cnt_reg >= CNT_W'(16));

endmodule

// File: rtl/ct_packer.sv
// ----------------------------------------------------------------------------
// ct_packer
// Ciphertext serializer behind the ML-KEM-768 encapsulation engine. After a
// start pulse it reads u[0..K-1] and v from the bank host port, ByteEncodes
// them little-endian and streams the 1088 ciphertext bytes over valid/ready.
//
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   start        one-cycle pulse; begins a run when idle
//   busy         run in progress (through the done cycle)
//   done         one-cycle pulse after the final byte handshake
//   rd_en        bank read strobe (data returns one cycle later)
//   rd_slot      bank slot address
//   rd_addr      coefficient index
//   rd_data      bank read data
//   out_valid    ciphertext byte available
//   out_data     ciphertext byte
//   out_ready    downstream accepts the byte
//   out_last     qualifies the final byte
// ----------------------------------------------------------------------------
module ct_packer
    import kyber_pkg::*;
#(
    parameter int K       = KYBER_K,
    parameter int DU      = KYBER_DU,
    parameter int DV      = KYBER_DV,
    parameter int SLOT_U0 = SLOT_CT_U0,
    parameter int SLOT_V  = SLOT_CT_V
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        rd_en,
    output logic [4:0]  rd_slot,
    output logic [7:0]  rd_addr,
    input  logic [11:0] rd_data,
    output logic        out_valid,
    output logic [7:0]  out_data,
    input  logic        out_ready,
    output logic        out_last
);

    ct_state_e   state_reg, state_next;
    logic [2:0]  poly_reg, poly_next;       // reaches K+1 once v is consumed
    logic [7:0]  idx_reg, idx_next;
    logic [10:0] byte_cnt_reg, byte_cnt_next;

    logic        is_u;
    logic        more_coefs;
    logic [3:0]  coef_width;

    logic        acc_clr, acc_load, acc_pop;
    logic [7:0]  acc_byte;
    logic        has_byte, load_has_byte, pop_has_byte;

    assign is_u       = (poly_reg < 3'(K));
    assign more_coefs = (poly_reg < 3'(K + 1));
    assign coef_width = is_u ? 4'(DU) : 4'(DV);

    ct_bit_accum #(
        .ACC_W  (24),
        .CNT_W  (5),
        .DATA_W (12),
        .WID_W  (4)
    ) u_accum (
        .clk           (clk),
        .rst           (rst),
        .clr           (acc_clr),
        .load          (acc_load),
        .load_width    (coef_width),
        .load_data     (rd_data),
        .pop           (acc_pop),
        .acc_byte      (acc_byte),
        .has_byte      (has_byte),
        .load_has_byte (load_has_byte),
        .pop_has_byte  (pop_has_byte)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            poly_reg     <= '0;
            idx_reg      <= '0;
            byte_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            poly_reg     <= poly_next;
            idx_reg      <= idx_next;
            byte_cnt_reg <= byte_cnt_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        poly_next     = poly_reg;
        idx_next      = idx_reg;
        byte_cnt_next = byte_cnt_reg;
        acc_clr       = 1'b0;
        acc_load      = 1'b0;
        acc_pop       = 1'b0;
        rd_en         = 1'b0;
        rd_slot       = '0;
        rd_addr       = '0;
        out_valid     = 1'b0;
        done          = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    state_next    = ST_FETCH;
                    poly_next     = '0;
                    idx_next      = '0;
                    byte_cnt_next = '0;
                    acc_clr       = 1'b1;
                end
            end

            ST_FETCH: begin
                rd_en      = 1'b1;
                rd_slot    = is_u ? (5'(SLOT_U0) + 5'(poly_reg)) : 5'(SLOT_V);
                rd_addr    = idx_reg;
                state_next = ST_LATCH;
            end

            ST_LATCH: begin
                acc_load = 1'b1;
                idx_next = idx_reg + 8'd1;
                if (idx_reg == 8'hFF) begin
                    poly_next = poly_reg + 3'd1;
                end
                state_next = load_has_byte ? ST_EMIT : ST_FETCH;
            end

            ST_EMIT: begin
                out_valid = has_byte;
                if (out_ready) begin
                    acc_pop       = 1'b1;
                    byte_cnt_next = byte_cnt_reg + 11'd1;
                    // Drain every whole byte before the next read; the stream
                    // ends with the bit count at exactly zero.
                    if (pop_has_byte) begin
                        state_next = ST_EMIT;
                    end else if (more_coefs) begin
                        state_next = ST_FETCH;
                    end else begin
                        state_next = ST_DONE;
                    end
                end
            end

            ST_DONE: begin
                done       = 1'b1;
                state_next = ST_IDLE;
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign busy     = (state_reg != ST_IDLE);
    assign out_data = acc_byte;
    assign out_last = out_valid && (byte_cnt_reg == 11'(CT_BYTES - 1));

endmodule
